// File: rtl/lvds_ddr_rx_align.sv
// Receive-side bitslip word aligner with training-pattern lock FSM for a 1:DEV_W DDR LVDS lane.
// Define LVDS_RX_ALIGN_ERRCNT_EN to build the locked-state mismatch counter driving err_count.
module lvds_ddr_rx_align #(
    parameter int               DEV_W     = 4,
    parameter logic [DEV_W-1:0] TRAIN_PAT = 4'b0011,
    parameter int               MATCH_CNT = 16,
    parameter int               MISS_CNT  = 4,
    parameter int               SLIP_WAIT = 2
) (
    input  logic                     clk_div_in,
    input  logic                     io_reset_n,
    input  logic [DEV_W-1:0]         data_in_from_serdes,
    input  logic                     data_in_valid,
    input  logic                     train_en,
    output logic [DEV_W-1:0]         data_out,
    output logic                     data_out_valid,
    output logic                     locked,
    output logic [$clog2(DEV_W)-1:0] slip_cnt,
    output logic                     align_err,
    output logic [15:0]              err_count
);

    localparam int SW = $clog2(DEV_W);
    localparam int MW = $clog2(MATCH_CNT + 1);
    localparam int XW = $clog2(MISS_CNT + 1);
    localparam int WW = $clog2(SLIP_WAIT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SEARCH    = 3'd1;
    localparam logic [2:0] S_SLIP_WAIT = 3'd2;
    localparam logic [2:0] S_VERIFY    = 3'd3;
    localparam logic [2:0] S_LOCKED    = 3'd4;

    localparam logic [SW-1:0] SLIP_MAX   = SW'(DEV_W - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_CNT - 1);
    localparam logic [XW-1:0] MISS_LAST  = XW'(MISS_CNT - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(SLIP_WAIT - 1);

    logic [DEV_W-1:0]   prev_q;
    logic [DEV_W-1:0]   dataOut_q;
    logic               dataOutValid_q;
    logic               upd_q;
    logic               trainDly_q;
    logic [2*DEV_W-1:0] pair;

    logic [2:0]    state_q,    state_d;
    logic [SW-1:0] slipCnt_q,  slipCnt_d;
    logic [MW-1:0] matchCnt_q, matchCnt_d;
    logic [XW-1:0] missCnt_q,  missCnt_d;
    logic [WW-1:0] waitCnt_q,  waitCnt_d;
    logic          hitSeen_q,  hitSeen_d;
    logic          locked_q,   locked_d;
    logic          alignErr_q, alignErr_d;

    logic cmpEv;
    logic isMatch;
    logic lockCmp;

    assign pair = {data_in_from_serdes, prev_q};

    always_ff @(posedge clk_div_in or negedge io_reset_n) begin
        if (!io_reset_n) begin
            prev_q         <= '0;
            dataOut_q      <= '0;
            dataOutValid_q <= 1'b0;
            upd_q          <= 1'b0;
            trainDly_q     <= 1'b0;
        end else begin
            upd_q          <= data_in_valid;
            dataOutValid_q <= data_in_valid & locked_q;
            trainDly_q     <= train_en;
            if (data_in_valid) begin
                prev_q    <= data_in_from_serdes;
                dataOut_q <= pair[slipCnt_q +: DEV_W];
            end
        end
    end

    // The candidate is the registered aligned word; it is only judged on the cycle after it was written.
    // In LOCKED the beat on which train_en falls is still judged so a final miss can drop lock.
    assign cmpEv   = upd_q;
    assign isMatch = (dataOut_q == TRAIN_PAT);
    assign lockCmp = cmpEv & (train_en | trainDly_q);

    always_comb begin
        state_d    = state_q;
        slipCnt_d  = slipCnt_q;
        matchCnt_d = matchCnt_q;
        missCnt_d  = missCnt_q;
        waitCnt_d  = waitCnt_q;
        hitSeen_d  = hitSeen_q;
        locked_d   = locked_q;
        alignErr_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (train_en) begin
                    state_d    = S_SEARCH;
                    matchCnt_d = '0;
                    missCnt_d  = '0;
                    locked_d   = 1'b0;
                    hitSeen_d  = 1'b0;
                end
            end
            S_SEARCH: begin
                if (!train_en) begin
                    state_d = S_IDLE;
                end else if (cmpEv) begin
                    if (isMatch) begin
                        state_d    = S_VERIFY;
                        matchCnt_d = MW'(1);
                        hitSeen_d  = 1'b1;
                    end else begin
                        state_d   = S_SLIP_WAIT;
                        waitCnt_d = '0;
                        slipCnt_d = (slipCnt_q == SLIP_MAX) ? '0 : slipCnt_q + 1'b1;
                        // A full sweep of offsets without any hit is reported, then the sweep restarts.
                        if (slipCnt_q == SLIP_MAX) begin
                            alignErr_d = ~hitSeen_q;
                            hitSeen_d  = 1'b0;
                        end
                    end
                end
            end
            S_SLIP_WAIT: begin
                if (!train_en) begin
                    state_d   = S_IDLE;
                    waitCnt_d = '0;
                end else if (cmpEv) begin
                    if (waitCnt_q == WAIT_LAST) begin
                        state_d   = S_SEARCH;
                        waitCnt_d = '0;
                    end else begin
                        waitCnt_d = waitCnt_q + 1'b1;
                    end
                end
            end
            S_VERIFY: begin
                if (!train_en) begin
                    state_d    = S_IDLE;
                    matchCnt_d = '0;
                end else if (cmpEv) begin
                    if (!isMatch) begin
                        state_d    = S_SEARCH;
                        matchCnt_d = '0;
                    end else if (matchCnt_q == MATCH_LAST) begin
                        state_d  = S_LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        matchCnt_d = matchCnt_q + 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                if (lockCmp) begin
                    if (isMatch) begin
                        missCnt_d = '0;
                    end else if (missCnt_q == MISS_LAST) begin
                        state_d    = S_SEARCH;
                        locked_d   = 1'b0;
                        missCnt_d  = '0;
                        matchCnt_d = '0;
                        hitSeen_d  = 1'b0;
                    end else begin
                        missCnt_d = missCnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_div_in or negedge io_reset_n) begin
        if (!io_reset_n) begin
            state_q    <= S_IDLE;
            slipCnt_q  <= '0;
            matchCnt_q <= '0;
            missCnt_q  <= '0;
            waitCnt_q  <= '0;
            hitSeen_q  <= 1'b0;
            locked_q   <= 1'b0;
            alignErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slipCnt_q  <= slipCnt_d;
            matchCnt_q <= matchCnt_d;
            missCnt_q  <= missCnt_d;
            waitCnt_q  <= waitCnt_d;
            hitSeen_q  <= hitSeen_d;
            locked_q   <= locked_d;
            alignErr_q <= alignErr_d;
        end
    end

`ifdef LVDS_RX_ALIGN_ERRCNT_EN
    logic [15:0] errCnt_q, errCnt_d;

    // Entering SEARCH wins over the increment, so the miss that drops lock leaves the counter cleared.
    always_comb begin
        errCnt_d = errCnt_q;
        if (state_d == S_SEARCH && state_q != S_SEARCH) begin
            errCnt_d = '0;
        end else if (state_q == S_LOCKED && lockCmp && !isMatch && errCnt_q != 16'hFFFF) begin
            errCnt_d = errCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_div_in or negedge io_reset_n) begin
        if (!io_reset_n) begin
            errCnt_q <= '0;
        end else begin
            errCnt_q <= errCnt_d;
        end
    end

    assign err_count = errCnt_q;
`else
    assign err_count = '0;
`endif

    assign data_out       = dataOut_q;
    assign data_out_valid = dataOutValid_q;
    assign locked         = locked_q;
    assign slip_cnt       = slipCnt_q;
    assign align_err      = alignErr_q;

endmodule

// File: doc/lvds_ddr_rx_align.md
Name: lvds_ddr_rx_align

Overview:
- Receive-side word aligner for a 4:1 DDR LVDS lane; counterpart of the DAC-side OSERDES transmit path, used on ADC/loopback inputs.
- Takes raw DEV_W-bit parallel words from an upstream 1:DEV_W deserializer (earliest bit at bit 0) and applies a fabric bitslip (barrel select across two consecutive words).
- Runs a training-pattern lock FSM and outputs aligned words with valid and lock status.

Parameters:
- DEV_W, 4, deserialization factor / word width.
- TRAIN_PAT, 4'b0011, aligned training word (bit 0 earliest).
- MATCH_CNT, 16, consecutive matches required to declare lock.
- MISS_CNT, 4, consecutive mismatches in LOCKED (training on) to drop lock.
- SLIP_WAIT, 2, valid beats ignored after each slip.

Ports:
- clk_div_in  input  1  word-rate clock, the single clock.
- io_reset_n  input  1  asynchronous active-low reset.
- data_in_from_serdes  input  DEV_W  raw deserialized word.
- data_in_valid  input  1  beat qualifier.
- train_en  input  1  training pattern present on lane.
- data_out  output  DEV_W  aligned word.
- data_out_valid  output  1  aligned word valid.
- locked  output  1  lane aligned.
- slip_cnt  output  $clog2(DEV_W)  current bit offset.
- align_err  output  1  one-cycle pulse: full slip wrap with no match.
- err_count  output  16  mismatch counter (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): data_out=0, data_out_valid=0, locked=0, slip_cnt=0, align_err=0, err_count=0, all counters 0, state IDLE. Mid-operation reset clears everything immediately.
- Datapath, on valid beats only:
  - prev <= data_in_from_serdes.
  - data_out <= {data_in_from_serdes, prev}[slip_cnt +: DEV_W].
  - data_out_valid <= data_in_valid & locked, registered alongside data_out.
- Latency: with slip_cnt=0, data_out shows a word 2 cycles after it is presented (continuous valid).
- Compare: candidate word = registered data_out value vs TRAIN_PAT, evaluated only on cycles where the register updated. Nothing advances without a valid beat.
- States:
  - IDLE:
    - train_en=1 -> SEARCH; clear match/miss counters and locked.
  - SEARCH:
    - Match -> VERIFY, match_cnt=1.
    - Mismatch -> slip_cnt=(slip_cnt+1) mod DEV_W, go SLIP_WAIT.
    - On the slip that wraps DEV_W-1 -> 0 with no match since entering SEARCH, pulse align_err for one cycle and keep searching.
  - SLIP_WAIT:
    - Count SLIP_WAIT valid beats, then -> SEARCH.
  - VERIFY:
    - Match increments match_cnt; reaching MATCH_CNT -> LOCKED with locked=1 on the same edge.
    - Mismatch -> SEARCH, match_cnt=0, slip unchanged.
  - LOCKED:
    - train_en=0: data mode, no compare, locked held.
    - train_en=1: compare each beat. Mismatch increments miss_cnt; a match clears it. miss_cnt==MISS_CNT -> locked=0, SEARCH, slip unchanged.
- train_en deasserted in SEARCH/SLIP_WAIT/VERIFY -> IDLE; locked stays 0, slip_cnt retained.
- Simultaneous events:
  - Reset dominates all.
  - A mismatch reaching MISS_CNT on the same beat as train_en falling still drops lock.

Optional Feature:
- Macro LVDS_RX_ALIGN_ERRCNT_EN.
- Defined: err_count increments on every LOCKED-state mismatch (train_en=1), saturates at 16'hFFFF, clears on entry to SEARCH.
- Undefined: err_count tied to 0 and no counter logic is built.

Test Plan:
- Parameters DEV_W=4, TRAIN_PAT=4'b0011, MATCH_CNT=16, MISS_CNT=4, SLIP_WAIT=2.
- Input 4'b0011 every cycle, train_en=1 -> slip_cnt stays 0; locked rises after 16 matching compares; data_out=4'b0011, data_out_valid=1 thereafter.
- Input 4'b1100 every cycle, train_en=1 -> slip_cnt steps 0->1->2 with 2 ignored beats per slip; locks at slip_cnt=2; data_out=4'b0011.
- Input 4'b0000, train_en=1 -> locked never asserts; align_err pulses once per 4 slips; slip_cnt cycles 0..3.
- After lock, train_en=0 with random data -> locked=1, data_out_valid mirrors delayed data_in_valid. Then train_en=1 with 4 consecutive 4'b0101 -> locked=0 on the 4th compare, state SEARCH, slip_cnt unchanged.
- data_in_valid toggled 1010... during VERIFY -> match_cnt advances only on valid beats; lock takes twice the cycles. Assert io_reset_n=0 mid-VERIFY -> all outputs 0 immediately.
- With LVDS_RX_ALIGN_ERRCNT_EN: 3 mismatches while locked (non-consecutive) -> err_count=3, locked=1. Without the macro -> err_count=0.
